// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache write-back path.
package cache_pkg;

  // Offset width for a given line size in bytes
  function automatic int off_w(input int line_size);
    return $clog2(line_size);
  endfunction

  localparam int LINE_SIZE_DEF = 16;
  localparam int LINE_OFFSET_W = off_w(LINE_SIZE_DEF);

  // Drain FSM encoding
  localparam logic [0:0] D_IDLE = 1'b0;
  localparam logic [0:0] D_BUSY = 1'b1;

  // Narrow queue entry fields; the line payload is held alongside it
  // because its width follows the LINE_SIZE parameter of the instance.
  typedef struct packed {
    logic        uncached;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_storage.sv
// Circular entry store for the write-back queue: payload array, pointers,
// occupancy count and per-slot valid/line-address views for hazard checks.
module wbq_storage
  import cache_pkg::*;
#(
  parameter  int DEPTH     = 4,
  parameter  int LINE_SIZE = 16,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int LINE_W    = LINE_SIZE * 8,
  localparam int LA_W      = 32 - off_w(LINE_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  wbq_entry_t                     i_ent,
  input  logic [LINE_W-1:0]              i_line,
  input  logic                           i_pop,
  output wbq_entry_t                     o_head,
  output logic [LINE_W-1:0]              o_head_line,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [DEPTH-1:0]               o_vld,
  output logic [DEPTH-1:0][LA_W-1:0]     o_laddr
);

  wbq_entry_t        r_mem  [DEPTH];
  logic [LINE_W-1:0] r_line [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  // Payload write; contents are don't-care until counted valid, so no reset
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr]  <= i_ent;
      r_line[r_wr_ptr] <= i_line;
    end
  end

  // Pointer/count bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_head_line = r_line[r_rd_ptr];
  assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty     = (r_count == '0);

  // A slot is live when its distance from the read pointer is below count
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] w_rel;
    assign w_rel      = PTR_W'(g) - r_rd_ptr;
    assign o_vld[g]   = ({1'b0, w_rel} < r_count);
    assign o_laddr[g] = r_mem[g].addr[31 -: LA_W];
  end

endmodule

// File: rtl/write_back_queue.sv
// Write-back queue between the D-cache store/victim path and the
// single-transaction AXI write buffer. Issues one entry at a time, waits for
// the buffer to drain, and reports line-address hazards for read misses.
module write_back_queue
  import cache_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic                   push_uncached,
  input  logic [31:0]            push_addr,
  input  logic [2:0]             push_size,
  input  logic [3:0]             push_wstrb,
  input  logic [31:0]            push_data,
  input  logic [LINE_SIZE*8-1:0] push_line,
  input  logic [31:0]            lookup_addr,
  output logic                   lookup_hit,
  output logic                   idle,
  output logic                   wb_en,
  output logic                   wb_uncached,
  output logic [31:0]            wb_addr,
  output logic [2:0]             wb_size,
  output logic [3:0]             wb_wstrb,
  output logic [31:0]            wb_data,
  output logic [LINE_SIZE*8-1:0] wb_line,
  input  logic                   wb_empty
);

  localparam int OFF_W = off_w(LINE_SIZE);
  localparam int LA_W  = 32 - OFF_W;

  wbq_entry_t                 w_push_ent;
  wbq_entry_t                 w_head;
  logic [LINE_SIZE*8-1:0]     w_head_line;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [DEPTH-1:0]           w_vld;
  logic [DEPTH-1:0][LA_W-1:0] w_laddr;
  logic [DEPTH-1:0]           w_ent_hit;
  logic [LA_W-1:0]            w_lookup_laddr;
  logic                       w_lookup_off_unused;

  logic [0:0]                 r_state;
  logic                       r_infl_vld;
  logic [LA_W-1:0]            r_infl_laddr;

  assign w_push_ent = '{uncached: push_uncached, addr: push_addr,
                        size: push_size, wstrb: push_wstrb, data: push_data};

  // Ready ignores a same-cycle pop to keep the path short
  assign push_ready = !w_full;
  assign w_push     = push_valid & push_ready;

  // Issue strobe; count is registered so a same-cycle push is never issued
  assign wb_en = (r_state == D_IDLE) & !w_empty & wb_empty;
  assign w_pop = wb_en;

  wbq_storage #(
    .DEPTH     (DEPTH),
    .LINE_SIZE (LINE_SIZE)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_ent       (w_push_ent),
    .i_line      (push_line),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_head_line (w_head_line),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_vld       (w_vld),
    .o_laddr     (w_laddr)
  );

  // Drain FSM plus the in-flight line address that covers the hand-off window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= D_IDLE;
      r_infl_vld   <= 1'b0;
      r_infl_laddr <= '0;
    end else begin
      case (r_state)
        D_IDLE: begin
          if (wb_en) begin
            r_state      <= D_BUSY;
            r_infl_vld   <= 1'b1;
            r_infl_laddr <= w_head.addr[31 -: LA_W];
          end
        end
        D_BUSY: begin
          if (wb_empty) begin
            r_state    <= D_IDLE;
            r_infl_vld <= 1'b0;
          end
        end
        default: r_state <= D_IDLE;
      endcase
    end
  end

  assign wb_uncached = w_head.uncached;
  assign wb_addr     = w_head.addr;
  assign wb_size     = w_head.size;
  assign wb_wstrb    = w_head.wstrb;
  assign wb_data     = w_head.data;
  assign wb_line     = w_head_line;

  // Line-granular hazard compare; uncached entries match conservatively
  assign w_lookup_laddr      = lookup_addr[31 -: LA_W];
  assign w_lookup_off_unused = ^lookup_addr[OFF_W-1:0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign w_ent_hit[g] = w_vld[g] & (w_laddr[g] == w_lookup_laddr);
  end

  assign lookup_hit = (|w_ent_hit) | (r_infl_vld & (r_infl_laddr == w_lookup_laddr));
  assign idle       = w_empty & (r_state == D_IDLE) & wb_empty;

endmodule
